// File: rtl/tda_job_scheduler.sv
// rtl/tda_job_scheduler.sv - FIFO-buffered round-robin job dispatcher for a pool of TDA units
// Optional per-unit watchdog: define TDA_SCHED_WATCHDOG_EN.
module tda_job_scheduler #(
   parameter int NUM_UNITS      = 8,
   parameter int ID_WIDTH       = 8,
   parameter int ADDR_WIDTH     = 16,
   parameter int QUEUE_DEPTH    = 16,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int UW = $clog2(NUM_UNITS),
   localparam int QW = $clog2(QUEUE_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [ID_WIDTH-1:0]   job_id,
   input  logic [ADDR_WIDTH-1:0] job_addr,
   output logic [NUM_UNITS-1:0]  unit_start,
   output logic [ADDR_WIDTH-1:0] unit_addr,
   input  logic [NUM_UNITS-1:0]  unit_done,
   output logic [NUM_UNITS-1:0]  unit_abort,
   output logic                  cpl_valid,
   input  logic                  cpl_ready,
   output logic [ID_WIDTH-1:0]   cpl_id,
   output logic [UW-1:0]         cpl_unit,
   output logic                  cpl_timeout,
   output logic [QW:0]           queue_level,
   output logic [NUM_UNITS-1:0]  busy_mask,
   output logic                  idle,
   output logic                  err_spurious,
   output logic                  err_timeout
);

   logic [ID_WIDTH-1:0]   fifo_id   [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr [QUEUE_DEPTH];
   logic [QW-1:0]         wr_ptr, rd_ptr;
   logic [QW:0]           count;
   logic                  full, empty, push, pop;

   logic [NUM_UNITS-1:0]  busy, pending, fire, tmo, hs_mask, cand;
   logic [ID_WIDTH-1:0]   tag [NUM_UNITS];
   logic [UW-1:0]         dispatch_ptr, cpl_ptr, disp_k, disp_idx, sel_k, sel_idx, sel_start;
   logic                  disp_found, sel_found, hs, load;

   function automatic logic [UW-1:0] next_unit(input logic [UW-1:0] k);
      return (int'(k) == NUM_UNITS - 1) ? '0 : k + 1'b1;
   endfunction

   assign full        = (count == (QW+1)'(QUEUE_DEPTH));
   assign empty       = (count == '0);
   assign job_ready   = !full;
   assign push        = job_valid && !full;
   assign queue_level = count;
   assign busy_mask   = busy;
   assign unit_abort  = fire;
   assign idle        = empty && (busy == '0) && (pending == '0) && !cpl_valid;

   always_comb begin
      disp_found = 1'b0;
      disp_k     = '0;
      disp_idx   = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         disp_idx = UW'((int'(dispatch_ptr) + i) % NUM_UNITS);
         if (!disp_found && !busy[disp_idx]) begin
            disp_found = 1'b1;
            disp_k     = disp_idx;
         end
      end
   end

   assign pop        = enable && !empty && disp_found;
   assign unit_start = pop ? (NUM_UNITS'(1) << disp_k) : '0;
   assign unit_addr  = pop ? fifo_addr[rd_ptr] : '0;

   // The record being handed off this cycle is excluded so the next one can load back-to-back.
   assign hs        = cpl_valid && cpl_ready;
   assign hs_mask   = hs ? (NUM_UNITS'(1) << cpl_unit) : '0;
   assign load      = !cpl_valid || cpl_ready;
   assign cand      = (pending | (unit_done & busy) | fire) & ~hs_mask;
   assign sel_start = hs ? next_unit(cpl_unit) : cpl_ptr;

   always_comb begin
      sel_found = 1'b0;
      sel_k     = '0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         sel_idx = UW'((int'(sel_start) + i) % NUM_UNITS);
         if (!sel_found && cand[sel_idx]) begin
            sel_found = 1'b1;
            sel_k     = sel_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         busy         <= '0;
         pending      <= '0;
         dispatch_ptr <= '0;
         cpl_ptr      <= '0;
         cpl_valid    <= 1'b0;
         cpl_id       <= '0;
         cpl_unit     <= '0;
         cpl_timeout  <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr       <= rd_ptr + 1'b1;
            dispatch_ptr <= next_unit(disp_k);
         end
         count        <= count + (QW+1)'(push) - (QW+1)'(pop);
         busy         <= (busy | unit_start) & ~hs_mask;
         pending      <= cand;
         err_spurious <= err_spurious | (|(unit_done & ~busy));
         if (hs) cpl_ptr <= next_unit(cpl_unit);
         if (load) begin
            cpl_valid <= sel_found;
            if (sel_found) begin
               cpl_id      <= tag[sel_k];
               cpl_unit    <= sel_k;
               cpl_timeout <= tmo[sel_k] | fire[sel_k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_id[wr_ptr]   <= job_id;
         fifo_addr[wr_ptr] <= job_addr;
      end
      if (pop) tag[disp_k] <= fifo_id[rd_ptr];
   end

`ifdef TDA_SCHED_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt [NUM_UNITS];

   // A done arriving in the same cycle as expiry wins as a normal completion.
   always_comb begin
      fire = '0;
      for (int k = 0; k < NUM_UNITS; k++)
         fire[k] = busy[k] & ~pending[k] & ~unit_done[k] & (wd_cnt[k] == CW'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_UNITS; k++) wd_cnt[k] <= '0;
         tmo         <= '0;
         err_timeout <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_UNITS; k++) begin
            if (unit_start[k])
               wd_cnt[k] <= '0;
            else if (busy[k] && !pending[k])
               wd_cnt[k] <= wd_cnt[k] + 1'b1;
         end
         tmo <= (tmo | fire) & ~hs_mask;
         if (|fire) err_timeout <= 1'b1;
      end
   end
`else
   assign fire        = '0;
   assign tmo         = '0;
   // always 0 without the watchdog
   assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
